fb_ram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port RGB565 frame-buffer RAM. Shares one RAM port between the LCD scan-out read path, which has absolute priority, and a pixel write path from the CNN/camera side. Writes are buffered in a small FIFO and drained into RAM in cycles the LCD does not request, such as blanking and porches. Sits between the LCD timing controller, the pixel producer and the frame RAM.

---
 rtl/fb_ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fb_ram_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_ram_arbiter.sv
// Single-port frame-buffer RAM arbiter: LCD reads have absolute priority, writes drain from an 8-deep FIFO.
// Optional write-stall counter port oWrStallCnt is enabled by defining FBARB_STALL_CNT_EN.
module fb_ram_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 3
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLcdRdReq,
  input  logic [ADDR_W-1:0] iLcdRdAddr,
  output logic [DATA_W-1:0] oLcdRdData,
  output logic              oLcdRdValid,
  input  logic              iWrValid,
  output logic              oWrReady,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oRamCs,
  output logic              oRamWe,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamWrData,
  input  logic [DATA_W-1:0] iRamRdData,
  output logic [FIFO_AW:0]  oFifoLevel
`ifdef FBARB_STALL_CNT_EN
  ,output logic [15:0]      oWrStallCnt
`endif
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } gnt_t;

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};

  gnt_t               gnt_r;
  gnt_t               gnt_nxt_s;
  logic               rd_phase_r;
  logic               wr_ready_r;
  logic [FIFO_AW:0]   level_r;
  logic [FIFO_AW:0]   level_nxt_s;
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  mem_addr_r [DEPTH];
  logic [DATA_W-1:0]  mem_data_r [DEPTH];

  assign empty_s    = (level_r == {(FIFO_AW+1){1'b0}});
  assign push_s     = iWrValid & wr_ready_r;
  assign pop_s      = (gnt_nxt_s == GNT_WR);
  assign oWrReady   = wr_ready_r;
  assign oFifoLevel = level_r;

  // Strict-priority grant decision for the next RAM cycle
  always_comb begin
    gnt_nxt_s = GNT_IDLE;
    if (iLcdRdReq) begin
      gnt_nxt_s = GNT_RD;
    end else if (!empty_s) begin
      gnt_nxt_s = GNT_WR;
    end else begin
      gnt_nxt_s = GNT_IDLE;
    end
  end

  // Next FIFO occupancy; push and pop together cancel out
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Grant FSM with registered RAM command and LCD read-return pipeline
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      gnt_r       <= GNT_IDLE;
      oRamCs      <= 1'b0;
      oRamWe      <= 1'b0;
      oRamAddr    <= {ADDR_W{1'b0}};
      oRamWrData  <= {DATA_W{1'b0}};
      rd_phase_r  <= 1'b0;
      oLcdRdValid <= 1'b0;
      oLcdRdData  <= {DATA_W{1'b0}};
    end else begin
      gnt_r <= gnt_nxt_s;
      case (gnt_nxt_s)
        GNT_RD: begin
          oRamCs   <= 1'b1;
          oRamWe   <= 1'b0;
          oRamAddr <= iLcdRdAddr;
        end
        GNT_WR: begin
          oRamCs     <= 1'b1;
          oRamWe     <= 1'b1;
          oRamAddr   <= mem_addr_r[rd_ptr_r];
          oRamWrData <= mem_data_r[rd_ptr_r];
        end
        default: begin
          oRamCs <= 1'b0;
          oRamWe <= 1'b0;
        end
      endcase
      // RAM data appears one cycle after the read command is on the bus
      rd_phase_r  <= (gnt_r == GNT_RD);
      oLcdRdValid <= rd_phase_r;
      if (rd_phase_r) begin
        oLcdRdData <= iRamRdData;
      end else begin
        oLcdRdData <= oLcdRdData;
      end
    end
  end

  // FIFO pointers, level and ready flag
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_r   <= {FIFO_AW{1'b0}};
      rd_ptr_r   <= {FIFO_AW{1'b0}};
      level_r    <= {(FIFO_AW+1){1'b0}};
      wr_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r    <= level_nxt_s;
      wr_ready_r <= (level_nxt_s < DEPTH_L);
    end
  end

  // FIFO storage; contents need no reset since the level gates every read
  always_ff @(posedge iClk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= iWrAddr;
      mem_data_r[wr_ptr_r] <= iWrData;
    end
  end

`ifdef FBARB_STALL_CNT_EN
  // Saturating count of cycles the producer is held off
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oWrStallCnt <= 16'h0000;
    end else if (iWrValid && !wr_ready_r && (oWrStallCnt != 16'hFFFF)) begin
      oWrStallCnt <= oWrStallCnt + 16'h0001;
    end else begin
      oWrStallCnt <= oWrStallCnt;
    end
  end
`endif

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Self-checking bench for fb_ram_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based transaction model with a behavioural RAM.
module tb_fb_ram_arbiter;
  localparam int AW = 17;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] lcd_data;
  logic          lcd_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd;
  logic [DW-1:0] ram_rd;
  logic [3:0]    level;
`ifdef FBARB_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  fb_ram_arbiter dut (
    .iClk(clk), .iRst(rst),
    .iLcdRdReq(rd_req), .iLcdRdAddr(rd_addr),
    .oLcdRdData(lcd_data), .oLcdRdValid(lcd_valid),
    .iWrValid(wr_valid), .oWrReady(wr_ready), .iWrAddr(wr_addr), .iWrData(wr_data),
    .oRamCs(ram_cs), .oRamWe(ram_we), .oRamAddr(ram_addr), .oRamWrData(ram_wd),
    .iRamRdData(ram_rd), .oFifoLevel(level)
`ifdef FBARB_STALL_CNT_EN
    , .oWrStallCnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: unwritten words read as addr + 16'h1000, one-cycle read latency
  bit [DW-1:0] dev_mem [0:(1<<AW)-1];
  bit          dev_vld [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        dev_mem[ram_addr] <= ram_wd;
        dev_vld[ram_addr] <= 1'b1;
      end else begin
        ram_rd <= dev_vld[ram_addr] ? dev_mem[ram_addr] : (16'(ram_addr) + 16'h1000);
      end
    end
  end

  // Reference model: pending writes as a queue, read results as a time-tagged queue
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int unsigned due; logic [DW-1:0] d; } rd_t;
  wr_t q[$];
  rd_t rdq[$];
  bit [DW-1:0] sh_mem [0:(1<<AW)-1];
  bit          sh_vld [0:(1<<AW)-1];
  logic          m_cs, m_we, m_valid, m_ready_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_data;
  int unsigned   edge_n = 0;
  int            m_stall;
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return sh_vld[a] ? sh_mem[a] : (16'(a) + 16'h1000);
  endfunction

  function automatic bit m_ready();
    return m_ready_en && (q.size() < 8);
  endfunction

  task automatic model_reset();
    q.delete();
    rdq.delete();
    m_cs = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0;
    m_valid = 1'b0; m_data = '0; m_ready_en = 1'b0; m_stall = 0;
  endtask

  task automatic model_step();
    bit  rdy;
    bit  empty;
    wr_t w;
    rdy   = m_ready();
    empty = (q.size() == 0);
    edge_n++;
    m_valid = 1'b0;
    if (rdq.size() > 0 && rdq[0].due == edge_n) begin
      m_valid = 1'b1;
      m_data  = rdq[0].d;
      void'(rdq.pop_front());
    end
    if (m_cs && m_we) begin
      sh_mem[m_addr] = m_wd;
      sh_vld[m_addr] = 1'b1;
    end else if (m_cs) begin
      rdq.push_back('{edge_n + 1, sh_rd(m_addr)});
    end
    if (rd_req) begin
      m_cs = 1'b1; m_we = 1'b0; m_addr = rd_addr;
    end else if (!empty) begin
      w = q.pop_front();
      m_cs = 1'b1; m_we = 1'b1; m_addr = w.a; m_wd = w.d;
    end else begin
      m_cs = 1'b0; m_we = 1'b0;
    end
    if (wr_valid && rdy) q.push_back('{wr_addr, wr_data});
    if (wr_valid && !rdy && m_stall != 65535) m_stall++;
    m_ready_en = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    chk("ram_cmd", {ram_cs, ram_we, ram_addr, ram_wd}, {m_cs, m_we, m_addr, m_wd});
    chk("fifo_level", 64'(level), 64'(q.size()));
    chk("wr_ready", 64'(wr_ready), 64'(m_ready()));
    chk("lcd_rd", {lcd_valid, lcd_data}, {m_valid, m_data});
`ifdef FBARB_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic rq, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic rq; logic [AW-1:0] ra; logic wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic [34:0] cmd; logic [3:0] lvl; logic [16:0] rd;
  } vec_t;

  function automatic vec_t v(input logic rq, input int ra, input logic wv, input int wa,
                             input logic [DW-1:0] wd, input logic cs, input logic we, input int ca,
                             input logic [DW-1:0] cd, input int lvl, input logic vld, input logic [DW-1:0] dat);
    vec_t r;
    r.rq = rq; r.ra = AW'(ra); r.wv = wv; r.wa = AW'(wa); r.wd = wd;
    r.cmd = {cs, we, AW'(ca), cd}; r.lvl = 4'(lvl); r.rd = {vld, dat};
    return r;
  endfunction

  vec_t tbl [16];

  initial begin
    int acc, we_seen, vld_seen;
    tbl[0]  = v(1,0, 0,0,16'h0,     1,0,0, 16'h0,    0, 0,16'h0);
    tbl[1]  = v(1,1, 0,0,16'h0,     1,0,1, 16'h0,    0, 0,16'h0);
    tbl[2]  = v(1,2, 0,0,16'h0,     1,0,2, 16'h0,    0, 1,16'h1000);
    tbl[3]  = v(1,3, 0,0,16'h0,     1,0,3, 16'h0,    0, 1,16'h1001);
    tbl[4]  = v(1,4, 0,0,16'h0,     1,0,4, 16'h0,    0, 1,16'h1002);
    tbl[5]  = v(0,0, 0,0,16'h0,     0,0,4, 16'h0,    0, 1,16'h1003);
    tbl[6]  = v(0,0, 0,0,16'h0,     0,0,4, 16'h0,    0, 1,16'h1004);
    tbl[7]  = v(0,0, 0,0,16'h0,     0,0,4, 16'h0,    0, 0,16'h1004);
    tbl[8]  = v(0,0, 1,10,16'hF800, 0,0,4, 16'h0,    1, 0,16'h1004);
    tbl[9]  = v(0,0, 1,11,16'h07E0, 1,1,10,16'hF800, 1, 0,16'h1004);
    tbl[10] = v(0,0, 1,12,16'h001F, 1,1,11,16'h07E0, 1, 0,16'h1004);
    tbl[11] = v(0,0, 0,0,16'h0,     1,1,12,16'h001F, 0, 0,16'h1004);
    tbl[12] = v(0,0, 0,0,16'h0,     0,0,12,16'h001F, 0, 0,16'h1004);
    tbl[13] = v(1,10,0,0,16'h0,     1,0,10,16'h001F, 0, 0,16'h1004);
    tbl[14] = v(0,0, 0,0,16'h0,     0,0,10,16'h001F, 0, 0,16'h1004);
    tbl[15] = v(0,0, 0,0,16'h0,     0,0,10,16'h001F, 0, 1,16'hF800);

    model_reset();
    #1;
    do_reset(3);
    chk("reset_ready_low", 64'(wr_ready), 64'd0);
    for (int i = 0; i < 4; i++) step();
    chk("idle_outputs", {ram_cs, ram_we, ram_addr, ram_wd, lcd_valid, level, wr_ready},
        {1'b0, 1'b0, 17'd0, 16'd0, 1'b0, 4'd0, 1'b1});

    // Directed table: back-to-back reads, then writes draining in idle cycles
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rq, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      step();
      chk("tbl_cmd", 64'({ram_cs, ram_we, ram_addr, ram_wd}), 64'(tbl[i].cmd));
      chk("tbl_level", 64'(level), 64'(tbl[i].lvl));
      chk("tbl_lcd", 64'({lcd_valid, lcd_data}), 64'(tbl[i].rd));
    end

    // Read and write to address 5 pending together: read wins and sees old data
    drive(0, 17'd5, 1, 17'd5, 16'hBEEF); step();
    drive(1, 17'd5, 0, 17'd0, 16'h0);    step();
    chk("hazard_rd_cmd", {ram_cs, ram_we, ram_addr}, {1'b1, 1'b0, 17'd5});
    drive(0, 17'd0, 0, 17'd0, 16'h0);    step();
    chk("hazard_wr_cmd", {ram_cs, ram_we, ram_addr, ram_wd}, {1'b1, 1'b1, 17'd5, 16'hBEEF});
    step();
    chk("hazard_old_data", {lcd_valid, lcd_data}, {1'b1, 16'h1005});
    for (int i = 0; i < 3; i++) step();

    // Randomized traffic; producer holds its data while not accepted
    for (int i = 0; i < 400; i++) begin
      bit hold;
      hold = wr_valid && !m_ready();
      rd_req  = ($urandom_range(0, 9) < 4);
      rd_addr = AW'($urandom_range(0, 15));
      if (!hold) begin
        wr_valid = ($urandom_range(0, 1) == 1);
        wr_addr  = AW'($urandom_range(0, 15));
        wr_data  = DW'($urandom);
      end
      step();
    end

    // Reset with writes pending and reads in flight
    drive(0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(20 + i), 1, AW'(40 + i), DW'(16'h5500 + i));
      step();
    end
    drive(0, 0, 0, 0, 16'h0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_level", 64'(level), 64'd0);
    @(negedge clk);
    compare_all();
    vld_seen = 0; we_seen = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      vld_seen += int'(lcd_valid); we_seen += int'(ram_cs & ram_we);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      vld_seen += int'(lcd_valid); we_seen += int'(ram_cs & ram_we);
    end
    chk("rst_no_valid", 64'(vld_seen), 64'd0);
    chk("rst_no_write", 64'(we_seen), 64'd0);
    chk("rst_fifo_empty", 64'(level), 64'd0);
    drive(1, 17'd42, 0, 0, 16'h0); step();
    drive(0, 0, 0, 0, 16'h0); step(); step();
    chk("rst_resume_rd", {lcd_valid, lcd_data}, {1'b1, 16'h102A});

    // Starvation: reads held for 20 cycles while writes keep being offered
    do_reset(2);
    step();
    acc = 0; we_seen = 0;
    for (int i = 0; i < 20; i++) begin
      bit take;
      take = wr_ready;
      drive(1, AW'(i), 1, AW'(100 + acc), DW'(16'hA000 + acc));
      step();
      if (take) acc++;
      we_seen += int'(ram_cs & ram_we);
    end
    chk("starve_accepted", 64'(acc), 64'd8);
    chk("starve_no_write", 64'(we_seen), 64'd0);
    chk("starve_ready_low", {wr_ready, level}, {1'b0, 4'd8});
`ifdef FBARB_STALL_CNT_EN
    chk("starve_stall_cnt", 64'(stall_cnt), 64'd12);
`endif
    drive(0, 0, 0, 0, 16'h0);
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      we_seen += int'(ram_cs & ram_we);
      if (i == 7) chk("drain_8_cycles", 64'(level), 64'd0);
    end
    chk("drain_count", 64'(we_seen), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
